// File: rtl/edge_pe_fetch.sv
`default_nettype none
// ============================================================================
// Module      : edge_pe_fetch
// Description : Per-PE edge-task front end. Accepts one task (base address,
//               packet count, replay iteration) while idle and fetches the
//               task's packets from the shared edge SRAM under a req/grant
//               handshake. Fetched packets are buffered in a small FIFO and
//               streamed to the Edge PE datapath.
//
// Ports       : clk        - single clock, all state on the rising edge
//               reset      - asynchronous, active-low clear
//               task_*     - task offer from the reservation station
//               pe_idle    - PE ready for a new task
//               mem_req    - edge SRAM bus request (held for the whole fetch)
//               mem_grant  - edge SRAM bus grant
//               mem_rd_en  - read strobe, mem_addr - read address
//               mem_rdata  - read data, valid one cycle after mem_rd_en
//               out_*      - FIFO head towards the PE datapath
//               out_ready  - datapath consumes the head when high
//
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pe_fetch #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 6,
    parameter int ITER_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              task_valid,
    input  logic [ADDR_W-1:0] task_addr,
    input  logic [CNT_W-1:0]  task_num,
    input  logic [ITER_W-1:0] task_iter,
    output logic              pe_idle,
    output logic              mem_req,
    input  logic              mem_grant,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_occ_w = c_ptr_w + 1;
    localparam logic [c_occ_w-1:0] c_depth = c_occ_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_remaining;
    logic [ITER_W-1:0]   r_iter;
    logic                r_inflight;       // read issued last cycle, data on mem_rdata now
    logic                r_inflight_last;  // that read was the task's final one

    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_occ_w-1:0]  r_count;

    logic                w_accept;
    logic                w_credit_ok;
    logic                w_final_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_empty;

    assign w_fifo_empty  = (r_count == '0);
    // An outstanding read already owns a slot, so it is counted against the
    // free space; this is what makes FIFO overflow impossible.
    assign w_credit_ok   = ((r_count + c_occ_w'(r_inflight)) < c_depth);
    assign w_push        = r_inflight;
    assign w_pop         = out_ready & ~w_fifo_empty;
    assign w_final_issue = mem_rd_en & (r_remaining == CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        pe_idle      = 1'b0;
        mem_req      = 1'b0;
        mem_rd_en    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                pe_idle = 1'b1;
                // A null task is consumed here without leaving IDLE.
                if (task_valid && (task_num != '0)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_rd_en = mem_grant & w_credit_ok & (r_remaining != '0);
                if (mem_rd_en && (r_remaining == CNT_W'(1))) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave on the cycle the last entry is popped so pe_idle is
                // back the very next cycle.
                if (!r_inflight &&
                    (w_fifo_empty || ((r_count == c_occ_w'(1)) && out_ready))) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and FIFO bookkeeping state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_iter          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_addr      <= task_addr;
                r_remaining <= task_num;
                r_iter      <= task_iter;
            end else if (mem_rd_en) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - CNT_W'(1);
            end

            r_inflight      <= mem_rd_en;
            r_inflight_last <= w_final_issue;

            if (w_push) begin
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_occ_w'(1);
                2'b01:   r_count <= r_count - c_occ_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Packet storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
        end
    end

    assign mem_addr  = r_addr;
    assign out_valid = ~w_fifo_empty;
    assign out_data  = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign out_last  = out_valid & r_fifo_last[r_rd_ptr];
    assign out_iter  = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_edge_pe_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_pe_fetch
// Description : Directed self-checking bench for edge_pe_fetch. A simple SRAM
//               model returns a address-tagged packet one cycle after each
//               read strobe; a monitor logs issued addresses and consumed
//               output beats for comparison against hand-derived streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_pe_fetch;

    logic        clk;
    logic        reset;
    logic        task_valid;
    logic [9:0]  task_addr;
    logic [5:0]  task_num;
    logic [1:0]  task_iter;
    logic        pe_idle;
    logic        mem_req;
    logic        mem_grant;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_iter;
    logic        out_last;
    logic        out_ready;

    int n_asserts;
    int n_fail;

    logic [9:0]  rd_q [$];
    logic [63:0] od_q [$];
    logic        ol_q [$];

    edge_pe_fetch #(
        .ADDR_W     (10),
        .DATA_W     (64),
        .CNT_W      (6),
        .ITER_W     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .task_valid (task_valid),
        .task_addr  (task_addr),
        .task_num   (task_num),
        .task_iter  (task_iter),
        .pe_idle    (pe_idle),
        .mem_req    (mem_req),
        .mem_grant  (mem_grant),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_iter   (out_iter),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pkt(input logic [9:0] a);
        return {16'hC0DE, 38'd0, a};
    endfunction

    // SRAM model: data valid exactly one cycle after the strobe, junk otherwise.
    initial mem_rdata = 64'd0;
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? pkt(mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // Monitor on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (out_valid && out_ready) begin
            od_q.push_back(out_data);
            ol_q.push_back(out_last);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        od_q.delete();
        ol_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pe_idle"},   pe_idle,   1'b1);
        check({tag, "_mem_req"},   mem_req,   1'b0);
        check({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
        check({tag, "_mem_addr"},  mem_addr,  10'h000);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"},  out_data,  64'd0);
        check({tag, "_out_last"},  out_last,  1'b0);
        check({tag, "_out_iter"},  out_iter,  2'd0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (pe_idle !== 1'b1 && n < max_cycles) begin
            tick();
            #1;
            n++;
        end
        check("wait_idle", pe_idle, 1'b1);
    endtask

    // Issued addresses must be base..base+n-1 (mod 1024), each delivered once,
    // in order, with the last flag only on the final beat.
    task automatic check_stream(input string tag, input logic [9:0] base, input int n);
        logic [9:0] a;
        check({tag, "_nreads"}, 64'(rd_q.size()), 64'(n));
        check({tag, "_nbeats"}, 64'(od_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            if (i < rd_q.size()) check({tag, "_rd_addr"}, rd_q[i], a);
            if (i < od_q.size()) begin
                check({tag, "_data"}, od_q[i], pkt(a));
                check({tag, "_last"}, ol_q[i], (i == n - 1) ? 1'b1 : 1'b0);
            end
        end
    endtask

    initial begin
        n_asserts  = 0;
        n_fail     = 0;
        reset      = 1'b0;
        task_valid = 1'b0;
        task_addr  = '0;
        task_num   = '0;
        task_iter  = '0;
        mem_grant  = 1'b0;
        out_ready  = 1'b0;

        // ---------------- reset ----------------
        repeat (3) tick();
        #1 check_reset_vals("rst");
        tick();
        reset     = 1'b1;
        mem_grant = 1'b1;
        out_ready = 1'b1;
        tick();
        #1 check_reset_vals("post_rst");

        // ---------------- basic 3-packet task ----------------
        clear_logs();
        tick();                                 // cycle t
        task_valid = 1'b1; task_addr = 10'h010; task_num = 6'd3; task_iter = 2'd1;
        #1 check("t1_idle_t", pe_idle, 1'b1);
        tick();                                 // t+1
        task_valid = 1'b0;
        #1;
        check("t1_idle_t1", pe_idle, 1'b0);
        check("t1_req_t1", mem_req, 1'b1);
        check("t1_rd_t1", mem_rd_en, 1'b1);
        check("t1_addr_t1", mem_addr, 10'h010);
        check("t1_ov_t1", out_valid, 1'b0);
        tick();                                 // t+2
        #1;
        check("t1_rd_t2", mem_rd_en, 1'b1);
        check("t1_addr_t2", mem_addr, 10'h011);
        check("t1_ov_t2", out_valid, 1'b0);
        tick();                                 // t+3
        #1;
        check("t1_rd_t3", mem_rd_en, 1'b1);
        check("t1_addr_t3", mem_addr, 10'h012);
        check("t1_ov_t3", out_valid, 1'b1);
        check("t1_data_t3", out_data, pkt(10'h010));
        check("t1_last_t3", out_last, 1'b0);
        check("t1_iter_t3", out_iter, 2'd1);
        tick();                                 // t+4
        #1;
        check("t1_req_t4", mem_req, 1'b0);
        check("t1_rd_t4", mem_rd_en, 1'b0);
        check("t1_data_t4", out_data, pkt(10'h011));
        check("t1_last_t4", out_last, 1'b0);
        tick();                                 // t+5
        #1;
        check("t1_ov_t5", out_valid, 1'b1);
        check("t1_data_t5", out_data, pkt(10'h012));
        check("t1_last_t5", out_last, 1'b1);
        check("t1_idle_t5", pe_idle, 1'b0);
        tick();                                 // t+6
        #1;
        check("t1_idle_t6", pe_idle, 1'b1);
        check("t1_ov_t6", out_valid, 1'b0);
        check("t1_iter_hold", out_iter, 2'd1);
        check_stream("t1", 10'h010, 3);

        // ---------------- null task ----------------
        clear_logs();
        tick();
        task_valid = 1'b1; task_addr = 10'h020; task_num = 6'd0; task_iter = 2'd3;
        tick();
        task_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("null_idle", pe_idle, 1'b1);
            check("null_req", mem_req, 1'b0);
            tick();
        end
        check("null_nreads", 64'(rd_q.size()), 64'd0);
        check("null_nbeats", 64'(od_q.size()), 64'd0);
        check("null_iter", out_iter, 2'd1);

        // ---------------- address wrap ----------------
        clear_logs();
        tick();
        task_valid = 1'b1; task_addr = 10'h3FE; task_num = 6'd4; task_iter = 2'd2;
        tick();
        task_valid = 1'b0;
        #1 wait_idle(40);
        check_stream("wrap", 10'h3FE, 4);
        check("wrap_iter", out_iter, 2'd2);

        // ---------------- back-pressure: credit limit ----------------
        clear_logs();
        out_ready = 1'b0;
        tick();
        task_valid = 1'b1; task_addr = 10'h100; task_num = 6'd8; task_iter = 2'd3;
        tick();
        task_valid = 1'b0;
        repeat (10) tick();
        #1;
        check("bp_nreads", 64'(rd_q.size()), 64'd4);
        check("bp_rd_stalled", mem_rd_en, 1'b0);
        check("bp_req_held", mem_req, 1'b1);
        check("bp_ov", out_valid, 1'b1);
        check("bp_head", out_data, pkt(10'h100));
        out_ready = 1'b1;
        wait_idle(60);
        check_stream("bp", 10'h100, 8);

        // ---------------- grant loss mid-task ----------------
        clear_logs();
        tick();
        task_valid = 1'b1; task_addr = 10'h200; task_num = 6'd5; task_iter = 2'd0;
        tick();                                 // t+1: read base
        task_valid = 1'b0;
        tick();                                 // t+2: read base+1
        tick();                                 // t+3..t+5: grant removed
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gl_req_held", mem_req, 1'b1);
            check("gl_rd_paused", mem_rd_en, 1'b0);
            tick();
        end
        mem_grant = 1'b1;                       // t+6
        #1;
        check("gl_resume_rd", mem_rd_en, 1'b1);
        check("gl_resume_addr", mem_addr, 10'h202);
        wait_idle(40);
        check_stream("gl", 10'h200, 5);

        // ---------------- busy-time task + reset mid-FETCH ----------------
        clear_logs();
        tick();
        task_valid = 1'b1; task_addr = 10'h300; task_num = 6'd6; task_iter = 2'd2;
        tick();                                 // busy: offer a different task
        task_addr = 10'h3A0; task_num = 6'd2; task_iter = 2'd3;
        #1 check("busy_idle", pe_idle, 1'b0);
        tick();
        tick();
        task_valid = 1'b0;
        #1;
        check("busy_req", mem_req, 1'b1);
        check("busy_first_addr", rd_q[0], 10'h300);
        check("busy_iter", out_iter, 2'd2);
        #1 reset = 1'b0;                        // asynchronous, mid-cycle
        #1 check_reset_vals("mid_rst");
        clear_logs();
        tick();
        tick();
        reset = 1'b1;
        #1 check_reset_vals("after_rst");
        repeat (6) tick();
        #1;
        check("after_rst_nreads", 64'(rd_q.size()), 64'd0);
        check("after_rst_nbeats", 64'(od_q.size()), 64'd0);
        check("after_rst_idle", pe_idle, 1'b1);
        check("after_rst_ov", out_valid, 1'b0);

        // ---------------- single-packet task after recovery ----------------
        clear_logs();
        tick();
        task_valid = 1'b1; task_addr = 10'h055; task_num = 6'd1; task_iter = 2'd1;
        tick();
        task_valid = 1'b0;
        #1 wait_idle(20);
        check_stream("one", 10'h055, 1);
        check("one_iter", out_iter, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_pe_fetch.md
# edge_pe_fetch

Per-PE task front end directly downstream of the packet-SRAM dispatch stage's reservation station. It accepts one edge task (base address, packet count, replay iteration) while the PE is idle and fetches the task's packets from the shared edge SRAM under a request/grant handshake. It buffers the fetched packets in a small FIFO and streams them to the Edge PE datapath. It drives the PE-idle bit that the reservation station uses to choose dispatch targets.

## Interface
Parameters:
- ADDR_W, 10, edge SRAM word-address width
- DATA_W, 64, packet width (one SRAM word per packet)
- CNT_W, 6, task packet-count width
- ITER_W, 2, replay-iteration tag width
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- task_valid  in  1  task present from the reservation station
- task_addr  in  ADDR_W  first packet address
- task_num  in  CNT_W  packet count; 0 is a null task
- task_iter  in  ITER_W  replay iteration tag
- pe_idle  out  1  PE ready for a new task
- mem_req  out  1  edge SRAM bus request
- mem_grant  in  1  edge SRAM bus grant, sampled every cycle
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_W  FIFO head packet
- out_iter  out  ITER_W  iteration tag of the current task
- out_last  out  1  head is the task's final packet
- out_ready  in  1  PE datapath consumes the head when high with out_valid

## Operation
- Three-state FSM: IDLE, FETCH, DRAIN.
- IDLE: pe_idle=1. A task is accepted on any cycle with task_valid=1.
  - task_num=0: the task is consumed with no other effect, and the FSM stays in IDLE.
  - Otherwise the block latches addr, remaining=task_num and iter, then moves to FETCH.
- task_valid while pe_idle=0 is ignored. It is neither stored nor errored.
- FETCH: mem_req=1.
  - credit = FIFO_DEPTH − occupancy − inflight, where inflight is a 1-bit flag for a read issued in the previous cycle.
  - mem_rd_en = mem_req & mem_grant & (credit>0) & (remaining>0). This is combinational from registered state and mem_grant.
  - mem_addr = current address.
  - Each issue increments the address modulo 2^ADDR_W and decrements remaining.
  - When the final read issues, the FSM moves to DRAIN and mem_req drops in the same transition.
  - Grant loss mid-task pauses issue with mem_req held high. Zero credit pauses issue the same way.
- Capture: on the cycle after each issue, mem_rdata is written to the FIFO. The entry's last bit is set if it was the task's final read.
- DRAIN: mem_req=0. The FSM waits until inflight=0 and the FIFO is empty (last packet popped), then returns to IDLE.
- out_iter holds the latched iteration tag from task acceptance until the next acceptance.
- FIFO push and pop may occur in the same cycle, including when the FIFO is full. Credit gating makes overflow impossible, and a pop on an empty FIFO has no effect.

## Timing
- Reset values: pe_idle=1, mem_req=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, out_iter=0. FIFO is empty, FSM is in IDLE.
- Reset asserted mid-task abandons the task immediately. Late mem_rdata returns are discarded.
- Task accepted at cycle t:
  - pe_idle=0 and mem_req=1 at t+1.
  - If mem_grant=1 at t+1, the first mem_rd_en is at t+1.
  - Data is captured at the end of t+2, and out_valid=1 at t+3.
- Sustained throughput is one packet per cycle while grant is held and out_ready=1.
- pe_idle returns to 1 the cycle after the pop of the out_last entry, provided inflight=0.
- A new task can be accepted that same cycle, as soon as pe_idle=1.

## Test plan
- Task addr=0x010, num=3, iter=1, grant held high, out_ready=1 -> mem_rd_en at t+1..t+3 with addresses 0x010/0x011/0x012. out_valid at t+3..t+5, out_last only on the third packet, out_iter=1. pe_idle=1 at t+6.
- Task num=0 -> pe_idle stays 1, mem_req never asserts, no output.
- Task addr=0x3FE, num=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- num=8, out_ready=0 throughout -> exactly 4 reads issue, then mem_rd_en stays 0 with mem_req=1. Raising out_ready resumes at one issue per pop, with no data loss and in order.
- Grant dropped for 3 cycles after the second read of a num=5 task -> issue pauses, mem_req stays 1. It resumes at address base+2, and all 5 packets are delivered once each.
- reset pulsed low mid-FETCH, and task_valid with a different task asserted while pe_idle=0 -> after reset, all outputs are at reset values and the FIFO is empty. The busy-time task produces no reads.
